// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : rand_range_sampler
// Brief    : Draws one uniformly distributed value in [0, N-1] per request
//            from an external seed/next/number RNG, using mask-and-reject
//            sampling with a bounded number of draws and a subtractive
//            fallback. Also sequences seed loads so the generator never sees
//            a seed load and a next-number strobe in the same cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             clock
//   reset           synchronous, active-high reset
//   req_valid_i     request valid
//   req_ready_o     request ready (IDLE, no seed pending or arriving)
//   range_i         range N, latched on accept
//   rsp_valid_o     response valid (held until rsp_ready_i)
//   rsp_ready_i     response ready
//   rsp_value_o     sampled value
//   rsp_fallback_o  value came from the fallback path
//   seed_load_i     seed load request pulse (sampled in every state)
//   seed_i          seed value
//   rng_loadseed_o  generator load-seed strobe
//   rng_seed_o      generator seed
//   rng_next_o      generator next-number strobe
//   rng_num_i       generator number, valid the cycle after rng_next_o
//   rejects_o       saturating count of rejected draws
// ============================================================================
module rand_range_sampler #(
    parameter int WIDTH     = 32,
    parameter int OUT_W     = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [OUT_W-1:0] range_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [OUT_W-1:0] rsp_value_o,
    output logic             rsp_fallback_o,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic             rng_loadseed_o,
    output logic [WIDTH-1:0] rng_seed_o,
    output logic             rng_next_o,
    input  logic [WIDTH-1:0] rng_num_i,
    output logic [15:0]      rejects_o
);

    localparam logic [OUT_W-1:0] c_one       = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       c_max_tries = 8'(MAX_TRIES);
    localparam logic [15:0]      c_rej_max   = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MASK   = 3'd1,
        DRAW   = 3'd2,
        SAMPLE = 3'd3,
        RESP   = 3'd4,
        SEED   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [OUT_W-1:0] r_range;
    logic [OUT_W-1:0] r_mask;
    logic [OUT_W-1:0] r_value;
    logic             r_fallback;
    logic [7:0]       r_tries;
    logic [15:0]      r_rejects;
    logic [WIDTH-1:0] r_seed;
    logic             r_seed_pending;

    logic             w_accept;
    logic             w_small_range;
    logic [OUT_W-1:0] w_draw;
    logic             w_in_range;
    logic [7:0]       w_tries_inc;
    logic             w_exhausted;

    // Sets every bit below the most significant set bit, giving the smallest
    // all-ones mask that covers x.
    function automatic logic [OUT_W-1:0] smear(input logic [OUT_W-1:0] x);
        logic [OUT_W-1:0] m;
        m = x;
        for (int i = 1; i < OUT_W; i++) begin
            m = m | (x >> i);
        end
        return m;
    endfunction

    // Only the low OUT_W bits of the generator number take part in sampling.
    generate
        if (WIDTH > OUT_W) begin : g_unused_hi
            logic w_unused_num_hi;
            assign w_unused_num_hi = ^rng_num_i[WIDTH-1:OUT_W];
        end
    endgenerate

    // Ready is suppressed while a seed is pending or arriving so the seed
    // load always wins the IDLE slot; it is also held low during reset.
    assign req_ready_o   = !reset && (r_state == IDLE) && !r_seed_pending && !seed_load_i;
    assign w_accept      = req_valid_i && req_ready_o;
    assign w_small_range = (r_range <= c_one);
    assign w_draw        = rng_num_i[OUT_W-1:0] & r_mask;
    assign w_in_range    = (w_draw < r_range);
    assign w_tries_inc   = r_tries + 8'd1;
    assign w_exhausted   = (w_tries_inc == c_max_tries);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_seed_pending || seed_load_i) begin
                    w_state_next = SEED;
                end else if (w_accept) begin
                    w_state_next = MASK;
                end
            end
            MASK: begin
                w_state_next = w_small_range ? RESP : DRAW;
            end
            DRAW: begin
                w_state_next = SAMPLE;
            end
            SAMPLE: begin
                if (w_in_range || w_exhausted) begin
                    w_state_next = RESP;
                end else begin
                    w_state_next = DRAW;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            SEED: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_range        <= '0;
            r_mask         <= '0;
            r_value        <= '0;
            r_fallback     <= 1'b0;
            r_tries        <= '0;
            r_rejects      <= '0;
            r_seed         <= '0;
            r_seed_pending <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // A new seed pulse overrides any older captured seed; a pulse in
            // the SEED cycle itself keeps the flag set for another load.
            if (seed_load_i) begin
                r_seed         <= seed_i;
                r_seed_pending <= 1'b1;
            end else if (r_state == SEED) begin
                r_seed_pending <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept && !r_seed_pending && !seed_load_i) begin
                        r_range <= range_i;
                        r_tries <= '0;
                    end
                end
                MASK: begin
                    r_mask <= smear(r_range - c_one);
                    if (w_small_range) begin
                        r_value    <= '0;
                        r_fallback <= 1'b0;
                    end
                end
                SAMPLE: begin
                    if (w_in_range) begin
                        r_value    <= w_draw;
                        r_fallback <= 1'b0;
                    end else begin
                        if (r_rejects != c_rej_max) begin
                            r_rejects <= r_rejects + 16'd1;
                        end
                        r_tries <= w_tries_inc;
                        // mask < 2N, so a rejected draw minus N lands in range.
                        if (w_exhausted) begin
                            r_value    <= w_draw - r_range;
                            r_fallback <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered values or direct state decodes
    // ------------------------------------------------------------------
    assign rsp_valid_o    = (r_state == RESP);
    assign rng_next_o     = (r_state == DRAW);
    assign rng_loadseed_o = (r_state == SEED);
    assign rng_seed_o     = r_seed;
    assign rsp_value_o    = r_value;
    assign rsp_fallback_o = r_fallback;
    assign rejects_o      = r_rejects;

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_range_sampler
// Brief    : Directed self-checking bench for rand_range_sampler with a
//            scripted RNG model answering one cycle after rng_next_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rand_range_sampler;

    localparam int WIDTH     = 32;
    localparam int OUT_W     = 16;
    localparam int MAX_TRIES = 8;

    logic             clk;
    logic             reset;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [OUT_W-1:0] range_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [OUT_W-1:0] rsp_value_o;
    logic             rsp_fallback_o;
    logic             seed_load_i;
    logic [WIDTH-1:0] seed_i;
    logic             rng_loadseed_o;
    logic [WIDTH-1:0] rng_seed_o;
    logic             rng_next_o;
    logic [WIDTH-1:0] rng_num_i;
    logic [15:0]      rejects_o;

    int checks   = 0;
    int errors   = 0;
    int npulse   = 0;
    int nload    = 0;
    int noverlap = 0;
    int nhs      = 0;

    logic [WIDTH-1:0] rng_q[$];

    rand_range_sampler #(
        .WIDTH     (WIDTH),
        .OUT_W     (OUT_W),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .range_i        (range_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_value_o    (rsp_value_o),
        .rsp_fallback_o (rsp_fallback_o),
        .seed_load_i    (seed_load_i),
        .seed_i         (seed_i),
        .rng_loadseed_o (rng_loadseed_o),
        .rng_seed_o     (rng_seed_o),
        .rng_next_o     (rng_next_o),
        .rng_num_i      (rng_num_i),
        .rejects_o      (rejects_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scripted generator: next queued value, or all-ones once the script runs out.
    always @(posedge clk) begin
        if (rng_next_o) begin
            if (rng_q.size() > 0) rng_num_i <= rng_q.pop_front();
            else                  rng_num_i <= 32'hFFFF_FFFF;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (rsp_valid_o && rsp_ready_i) nhs++;
        @(posedge clk);
        #1;
        if (rng_next_o) npulse++;
        if (rng_loadseed_o) nload++;
        if (rng_next_o && rng_loadseed_o) noverlap++;
    endtask

    task automatic accept(input string tag, input logic [OUT_W-1:0] n);
        range_i     = n;
        req_valid_i = 1'b1;
        #1;
        check({tag, " ready"}, 64'(req_ready_o), 64'd1);
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid_o && lat < 64) begin
            step();
            lat++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check({tag, " valid drop"}, 64'(rsp_valid_o), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " req_ready"}, 64'(req_ready_o), 64'd0);
        check({tag, " rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        check({tag, " value"},     64'(rsp_value_o), 64'd0);
        check({tag, " fallback"},  64'(rsp_fallback_o), 64'd0);
        check({tag, " loadseed"},  64'(rng_loadseed_o), 64'd0);
        check({tag, " seed"},      64'(rng_seed_o), 64'd0);
        check({tag, " next"},      64'(rng_next_o), 64'd0);
        check({tag, " rejects"},   64'(rejects_o), 64'd0);
    endtask

    initial begin
        int lat;
        int p0;
        int l0;
        int h0;
        int seen;

        reset       = 1'b1;
        req_valid_i = 1'b0;
        range_i     = '0;
        rsp_ready_i = 1'b0;
        seed_load_i = 1'b0;
        seed_i      = '0;
        step();
        step();
        check_zero_outputs("reset");
        reset = 1'b0;
        step();

        // 1: first draw accepted
        rng_q.push_back(32'h0000_0007);
        p0 = npulse;
        accept("t1", 16'd10);
        wait_rsp(lat);
        check("t1 latency",  64'(lat), 64'd3);
        check("t1 pulses",   64'(npulse - p0), 64'd1);
        check("t1 value",    64'(rsp_value_o), 64'd7);
        check("t1 fallback", 64'(rsp_fallback_o), 64'd0);
        check("t1 rejects",  64'(rejects_o), 64'd0);
        finish_rsp("t1");
        check("t1 value held", 64'(rsp_value_o), 64'd7);

        // 2: two rejections, upper generator bits ignored
        rng_q.push_back(32'h0000_000C);
        rng_q.push_back(32'h0001_000F);
        rng_q.push_back(32'h0000_0003);
        p0 = npulse;
        accept("t2", 16'd10);
        wait_rsp(lat);
        check("t2 latency",  64'(lat), 64'd7);
        check("t2 pulses",   64'(npulse - p0), 64'd3);
        check("t2 value",    64'(rsp_value_o), 64'd3);
        check("t2 fallback", 64'(rsp_fallback_o), 64'd0);
        check("t2 rejects",  64'(rejects_o), 64'd2);
        finish_rsp("t2");

        // 3: every draw rejected -> fallback 15 - 9
        p0 = npulse;
        accept("t3", 16'd9);
        wait_rsp(lat);
        check("t3 latency",  64'(lat), 64'd17);
        check("t3 pulses",   64'(npulse - p0), 64'd8);
        check("t3 value",    64'(rsp_value_o), 64'd6);
        check("t3 fallback", 64'(rsp_fallback_o), 64'd1);
        check("t3 rejects",  64'(rejects_o), 64'd10);
        finish_rsp("t3");

        // 4: N = 0 and N = 1 answer without drawing
        p0 = npulse;
        accept("t4a", 16'd0);
        wait_rsp(lat);
        check("t4a latency",  64'(lat), 64'd1);
        check("t4a value",    64'(rsp_value_o), 64'd0);
        check("t4a fallback", 64'(rsp_fallback_o), 64'd0);
        finish_rsp("t4a");
        accept("t4b", 16'd1);
        wait_rsp(lat);
        check("t4b latency", 64'(lat), 64'd1);
        check("t4b value",   64'(rsp_value_o), 64'd0);
        check("t4 pulses",   64'(npulse - p0), 64'd0);
        finish_rsp("t4b");

        // 5: seed loads during SAMPLE wait for the request to finish
        rng_q.push_back(32'h0000_000C);
        rng_q.push_back(32'h0000_0005);
        l0 = nload;
        range_i     = 16'd10;
        req_valid_i = 1'b1;
        step();                 // accept -> MASK
        step();                 // DRAW
        step();                 // SAMPLE (reject)
        seed_load_i = 1'b1;
        seed_i      = 32'h1234_5678;
        step();                 // DRAW
        seed_load_i = 1'b0;
        check("t5 ready busy", 64'(req_ready_o), 64'd0);
        step();                 // SAMPLE (accept 5)
        seed_load_i = 1'b1;
        seed_i      = 32'hDEAD_BEEF;
        step();                 // RESP
        seed_load_i = 1'b0;
        check("t5 rsp valid",   64'(rsp_valid_o), 64'd1);
        check("t5 value",       64'(rsp_value_o), 64'd5);
        check("t5 rejects",     64'(rejects_o), 64'd11);
        check("t5 no load yet", 64'(nload - l0), 64'd0);
        range_i     = 16'd1;
        rsp_ready_i = 1'b1;
        step();                 // IDLE with seed pending
        rsp_ready_i = 1'b0;
        check("t5 ready pending", 64'(req_ready_o), 64'd0);
        step();                 // SEED
        check("t5 loadseed",      64'(rng_loadseed_o), 64'd1);
        check("t5 seed value",    64'(rng_seed_o), 64'(32'hDEAD_BEEF));
        check("t5 ready in seed", 64'(req_ready_o), 64'd0);
        check("t5 next in seed",  64'(rng_next_o), 64'd0);
        step();                 // IDLE
        check("t5 loadseed drop", 64'(rng_loadseed_o), 64'd0);
        check("t5 ready after",   64'(req_ready_o), 64'd1);
        check("t5 one load",      64'(nload - l0), 64'd1);
        step();                 // accept N = 1 -> MASK
        req_valid_i = 1'b0;
        step();                 // RESP
        check("t5b valid", 64'(rsp_valid_o), 64'd1);
        check("t5b value", 64'(rsp_value_o), 64'd0);
        finish_rsp("t5b");

        // 6a: backpressure on a fallback response
        accept("t6", 16'd9);
        wait_rsp(lat);
        check("t6 latency", 64'(lat), 64'd17);
        for (int i = 0; i < 5; i++) begin
            check("t6 hold valid",    64'(rsp_valid_o), 64'd1);
            check("t6 hold value",    64'(rsp_value_o), 64'd6);
            check("t6 hold fallback", 64'(rsp_fallback_o), 64'd1);
            step();
        end
        h0 = nhs;
        finish_rsp("t6");
        check("t6 one handshake", 64'(nhs - h0), 64'd1);
        check("t6 rejects",       64'(rejects_o), 64'd19);
        step();
        check("t6 stays idle", 64'(rsp_valid_o), 64'd0);

        // 6b: reset while in DRAW abandons the request
        rng_q.push_back(32'h0000_0007);
        accept("t7", 16'd10);
        step();                 // DRAW
        check("t7 in draw", 64'(rng_next_o), 64'd1);
        reset = 1'b1;
        h0    = nhs;
        step();
        check_zero_outputs("t7 reset");
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid_o) seen++;
        end
        check("t7 no response",  64'(seen), 64'd0);
        check("t7 no handshake", 64'(nhs - h0), 64'd0);

        check("strobe overlap",   64'(noverlap), 64'd0);
        check("total handshakes", 64'(nhs), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
